// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, console output FIFO, status register
// and a free-running cycle counter behind a single CPU memory port.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pmem_addr_in,
  input  logic [15:0] pmem_data_in,
  input  logic        pmem_write,
  output logic [15:0] pmem_data_out,
  output logic [15:0] con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  localparam logic [15:0] ADDR_CONSOLE = 16'hFF00;
  localparam logic [15:0] ADDR_STATUS  = 16'hFF01;
  localparam logic [15:0] ADDR_CYCLES  = 16'hFF02;

  logic [15:0]          ram      [RAM_DEPTH];
  logic [15:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 overflow;
  logic [15:0]          cycles;

  logic [ADDR_BITS-1:0] ram_idx;
  logic                 is_ram;
  logic                 is_con;
  logic                 is_status;
  logic                 is_cycles;
  logic                 wr_en;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 ovf_set;
  logic                 ovf_clr;
  logic                 cyc_load;
  logic [15:0]          status;
  logic [15:0]          rd_data;
  logic [15:0]          head_nxt;

  // Address decode, FIFO push/pop decisions and read-data selection
  always_comb begin
    ram_idx    = pmem_addr_in[ADDR_BITS-1:0];
    is_ram     = pmem_addr_in < ADDR_CONSOLE;
    is_con     = pmem_addr_in == ADDR_CONSOLE;
    is_status  = pmem_addr_in == ADDR_STATUS;
    is_cycles  = pmem_addr_in == ADDR_CYCLES;
    wr_en      = pmem_write && !rst;

    full       = count == CNT_W'(FIFO_DEPTH);
    empty      = count == '0;
    pop        = !rst && !empty && con_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push       = wr_en && is_con && (!full || pop);
    ovf_set    = wr_en && is_con && full && !pop;
    ovf_clr    = wr_en && is_status && pmem_data_in[0];
    cyc_load   = wr_en && is_cycles;

    status     = {4'b0, 4'(count), 5'b0, empty, full, overflow};

    rd_data = 16'h0000;
    if (is_ram) begin
      rd_data = ram[ram_idx];
    end else if (is_status) begin
      rd_data = status;
    end else if (is_cycles) begin
      rd_data = cycles;
    end

    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end

    rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Head after this edge; the pushed word becomes head when it lands at the new read pointer
    head_nxt = 16'h0000;
    if (count_nxt != '0) begin
      if (push && (rd_ptr_nxt == wr_ptr)) begin
        head_nxt = pmem_data_in;
      end else begin
        head_nxt = fifo_mem[rd_ptr_nxt];
      end
    end
  end

  // Storage arrays: RAM survives reset, FIFO slots are only meaningful via pointers
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) begin
      ram[ram_idx] <= pmem_data_in;
    end
    if (push) begin
      fifo_mem[wr_ptr] <= pmem_data_in;
    end
  end

  // Control state, registered read data and registered console outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pmem_data_out <= 16'h0000;
      con_data      <= 16'h0000;
      con_valid     <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      cycles        <= 16'h0000;
    end else begin
      pmem_data_out <= rd_data;
      con_data      <= head_nxt;
      con_valid     <= count_nxt != '0;
      rd_ptr        <= rd_ptr_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      cycles <= cyc_load ? pmem_data_in : cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized traffic against a queue/array reference model.
module tb_data_mem_responder;

  localparam int unsigned AB    = 8;
  localparam int unsigned FD    = 4;
  localparam int unsigned DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pmem_addr_in;
  logic [15:0] pmem_data_in;
  logic        pmem_write;
  logic [15:0] pmem_data_out;
  logic [15:0] con_data;
  logic        con_valid;
  logic        con_ready;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(AB), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_addr_in (pmem_addr_in),
    .pmem_data_in (pmem_data_in),
    .pmem_write   (pmem_write),
    .pmem_data_out(pmem_data_out),
    .con_data     (con_data),
    .con_valid    (con_valid),
    .con_ready    (con_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_ram   [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_q     [$];
  bit          m_ovf;
  logic [15:0] m_cyc;
  logic [15:0] m_dout;
  bit          m_dout_known;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock edge of the memory map, computed from the architectural rules
  task automatic model_step(input bit r, input bit w, input logic [15:0] a,
                            input logic [15:0] d, input bit rdy);
    int          sz;
    bit          pop;
    logic [15:0] rd;
    logic [AB-1:0] idx;
    if (r) begin
      m_dout       = 16'h0000;
      m_dout_known = 1'b1;
      m_q.delete();
      m_ovf        = 1'b0;
      m_cyc        = 16'h0000;
      return;
    end
    idx = a[AB-1:0];
    sz  = m_q.size();
    rd  = 16'h0000;
    m_dout_known = 1'b1;
    if (a < 16'hFF00) begin
      rd = m_ram[idx];
      m_dout_known = m_known[idx];
    end else if (a == 16'hFF01) begin
      rd = 16'(sz * 256 + (sz == 0 ? 4 : 0) + (sz == FD ? 2 : 0) + (m_ovf ? 1 : 0));
    end else if (a == 16'hFF02) begin
      rd = m_cyc;
    end
    m_dout = rd;
    pop = (sz > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (w && a == 16'hFF00) begin
      if (sz < FD || pop) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (w && a == 16'hFF01 && d[0]) m_ovf = 1'b0;
    m_cyc = (w && a == 16'hFF02) ? d : m_cyc + 16'd1;
    if (w && a < 16'hFF00) begin
      m_ram[idx]   = d;
      m_known[idx] = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_head;
    exp_head = (m_q.size() != 0) ? m_q[0] : 16'h0000;
    if (m_dout_known) check16("pmem_data_out", pmem_data_out, m_dout);
    check16("con_valid", 16'(con_valid), 16'(m_q.size() != 0));
    check16("con_data", con_data, exp_head);
  endtask

  // Drive one cycle at the falling edge, advance the model, check after the rising edge
  task automatic step(input bit r, input bit w, input logic [15:0] a,
                      input logic [15:0] d, input bit rdy);
    rst          = r;
    pmem_write   = w;
    pmem_addr_in = a;
    pmem_data_in = d;
    con_ready    = rdy;
    model_step(r, w, a, d, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    bit          w;
    bit          r;
    int          sel;

    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
    m_ovf = 1'b0;
    m_cyc = 16'h0000;
    m_dout = 16'h0000;
    m_dout_known = 1'b0;
    rst = 1'b1; pmem_write = 1'b0; pmem_addr_in = '0; pmem_data_in = '0; con_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1, 0, 16'h0000, 16'h0000, 0);
    step(1, 0, 16'h0000, 16'h0000, 0);
    check16("rst_dout", pmem_data_out, 16'h0000);
    check16("rst_valid", 16'(con_valid), 16'h0000);
    check16("rst_con_data", con_data, 16'h0000);

    // Fill RAM so every later read has a known expectation
    for (int i = 0; i < int'(DEPTH); i++) step(0, 1, 16'(i), 16'($urandom), 0);

    // Read latency and address aliasing
    step(0, 1, 16'h0010, 16'h1234, 0);
    step(0, 0, 16'h0010, 16'h0000, 0);
    check16("lat_read", pmem_data_out, 16'h1234);
    step(0, 0, 16'h0110, 16'h0000, 0);
    check16("alias_read", pmem_data_out, 16'h1234);

    // Read-before-write
    step(0, 1, 16'h0020, 16'hAAAA, 0);
    step(0, 1, 16'h0020, 16'h5555, 0);
    check16("rbw_old", pmem_data_out, 16'hAAAA);
    step(0, 0, 16'h0020, 16'h0000, 0);
    check16("rbw_new", pmem_data_out, 16'h5555);

    // FIFO overflow, overflow clear, drain
    for (int i = 1; i <= 5; i++) step(0, 1, 16'hFF00, 16'(i), 0);
    step(0, 0, 16'hFF01, 16'h0000, 0);
    check16("ovf_status", pmem_data_out, 16'h0403);
    step(0, 1, 16'hFF01, 16'h0001, 0);
    step(0, 0, 16'hFF01, 16'h0000, 0);
    check16("ovf_clr_status", pmem_data_out, 16'h0402);
    check16("drain_head1", con_data, 16'h0001);
    for (int i = 2; i <= 4; i++) begin
      step(0, 0, 16'h0010, 16'h0000, 1);
      check16("drain_head", con_data, 16'(i));
    end
    step(0, 0, 16'h0010, 16'h0000, 1);
    check16("drain_empty_valid", 16'(con_valid), 16'h0000);
    step(0, 0, 16'hFF01, 16'h0000, 0);
    check16("drain_status", pmem_data_out, 16'h0004);

    // Full FIFO with simultaneous push and pop
    for (int i = 5; i <= 8; i++) step(0, 1, 16'hFF00, 16'(i), 0);
    step(0, 1, 16'hFF00, 16'h0009, 1);
    check16("pp_head", con_data, 16'h0006);
    step(0, 0, 16'hFF01, 16'h0000, 0);
    check16("pp_status", pmem_data_out, 16'h0402);
    for (int i = 7; i <= 9; i++) begin
      step(0, 0, 16'h0010, 16'h0000, 1);
      check16("pp_drain", con_data, 16'(i));
    end
    step(0, 0, 16'h0010, 16'h0000, 1);
    check16("pp_empty_valid", 16'(con_valid), 16'h0000);

    // Cycle counter load and wrap
    step(0, 1, 16'hFF02, 16'hFFFE, 0);
    step(0, 0, 16'hFF02, 16'h0000, 0);
    check16("cyc_0", pmem_data_out, 16'hFFFE);
    step(0, 0, 16'hFF02, 16'h0000, 0);
    check16("cyc_1", pmem_data_out, 16'hFFFF);
    step(0, 0, 16'hFF02, 16'h0000, 0);
    check16("cyc_2", pmem_data_out, 16'h0000);

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) step(0, 1, 16'hFF00, 16'(16'h30 + i), 0);
    step(0, 1, 16'h0005, 16'h0077, 0);
    step(1, 1, 16'hFF00, 16'h00AA, 1);
    check16("mid_rst_valid", 16'(con_valid), 16'h0000);
    step(0, 0, 16'hFF02, 16'h0000, 0);
    check16("mid_rst_cycles", pmem_data_out, 16'h0000);
    step(0, 0, 16'hFF01, 16'h0000, 0);
    check16("mid_rst_status", pmem_data_out, 16'h0004);
    step(0, 0, 16'h0005, 16'h0000, 0);
    check16("mid_rst_ram", pmem_data_out, 16'h0077);

    // Randomized traffic across the whole map
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      r   = ($urandom_range(0, 199) == 0);
      w   = ($urandom_range(0, 2) == 0);
      d   = 16'($urandom);
      case (sel)
        0, 1, 2: a = 16'($urandom_range(0, 16'hFEFF));
        3:       a = 16'($urandom_range(0, 15) + 16'h0100 * $urandom_range(0, 3));
        4, 5:    begin a = 16'hFF00; w = ($urandom_range(0, 1) == 1); end
        6:       a = 16'hFF01;
        7:       a = 16'hFF02;
        default: a = 16'($urandom_range(16'hFF03, 16'hFFFF));
      endcase
      step(r, w, a, d, ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, giving log2 of the RAM depth in 16-bit words (legal range 4..15).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of console FIFO entries (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port pmem_addr_in, input, 16 bits, the word address driven by the CPU.
REQ-006 The block SHALL have port pmem_data_in, input, 16 bits, the write data driven by the CPU.
REQ-007 The block SHALL have port pmem_write, input, 1 bit, the write strobe; it is sampled every cycle.
REQ-008 The block SHALL have port pmem_data_out, output, 16 bits, the registered read data returned to the CPU.
REQ-009 The block SHALL have port con_data, output, 16 bits, the console FIFO head word.
REQ-010 The block SHALL have port con_valid, output, 1 bit, asserted when the FIFO is non-empty.
REQ-011 The block SHALL have port con_ready, input, 1 bit, the console sink ready signal.

Function
REQ-012 Read latency SHALL be one cycle: pmem_data_out after edge N reflects the address sampled at edge N and holds until edge N+1.
REQ-013 Reads SHALL occur every cycle regardless of pmem_write.
REQ-014 The RAM region SHALL be addresses 0x0000..0xFEFF.
  - The word index is pmem_addr_in[ADDR_BITS-1:0]; upper bits are ignored, so addresses alias and wrap.
REQ-015 A RAM write SHALL update the indexed word at the edge where pmem_write=1.
  - Read and write to the same word in the same cycle returns the old data (read-before-write).
REQ-016 Address 0xFF00 (CONSOLE) SHALL behave as follows.
  - Write: push pmem_data_in into the FIFO if it is not full.
  - Write while full with no pop in the same cycle: drop the data and set sticky overflow.
  - Read: returns 0x0000.
REQ-017 Address 0xFF01 (STATUS) SHALL behave as follows.
  - Read: bit0=overflow, bit1=full, bit2=empty, bits[11:8]=count; all other bits 0.
  - Write with pmem_data_in[0]=1: clears overflow. Other bits are ignored.
REQ-018 Address 0xFF02 (CYCLES) SHALL behave as follows.
  - Counter is a free-running 16-bit counter incrementing every cycle and wrapping 0xFFFF->0x0000.
  - Read: returns the counter value before that edge's update.
  - Write: loads pmem_data_in, taking priority over the increment.
REQ-019 Addresses 0xFF03..0xFFFF SHALL read 0x0000, and writes to them SHALL be ignored with no side effects.
REQ-020 con_valid SHALL equal !empty, and con_data SHALL equal the head entry; both are registered state, not combinational paths from pmem_*.
REQ-021 A pop SHALL occur when con_valid and con_ready are both 1 at an edge; con_ready while empty has no effect.
REQ-022 Push and pop at the same edge SHALL behave as follows.
  - Both take effect and count is unchanged.
  - When full, the push is accepted and overflow is not set.
  - When empty, only the push occurs (no bypass); con_valid rises the next cycle.
REQ-023 count SHALL range 0..FIFO_DEPTH, and the read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 While rst=1 at an edge, the following SHALL take effect.
  - pmem_data_out=0, con_valid=0, con_data=0.
  - FIFO empty with count=0, overflow=0, CYCLES=0.
  - Any concurrent pmem_write or pop is ignored.
REQ-025 RAM contents SHALL NOT be cleared by reset.
REQ-026 Reset mid-operation SHALL discard FIFO contents, and the first post-reset read SHALL return valid data one cycle after address presentation.

Verification
REQ-027 RAM latency scenario: write 0x1234 to 0x0010, then read 0x0010 the next cycle -> pmem_data_out=0x1234 one cycle later; with ADDR_BITS=8, read 0x0110 -> 0x1234 (alias).
REQ-028 Read-before-write scenario: 0x0020 holds 0xAAAA; write 0x5555 and read 0x0020 in the same cycle -> 0xAAAA; re-read -> 0x5555.
REQ-029 FIFO overflow scenario: con_ready=0, write 5 words 1..5 to 0xFF00 -> STATUS reads 0x0403 (count 4, full, overflow); write STATUS=0x0001 -> 0x0402; raise con_ready -> con_data sequence 1,2,3,4, then con_valid=0 and STATUS=0x0004.
REQ-030 Full push+pop scenario: FIFO full with con_ready=1 and push 0x0009 in the same cycle -> count stays 4, overflow stays 0, and 0x0009 emerges last.
REQ-031 CYCLES scenario: write 0xFFFE to 0xFF02, then read on the following cycles -> 0xFFFE, 0xFFFF, 0x0000.
REQ-032 Reset-mid-operation scenario: FIFO holds 3 words, RAM[0x5]=0x77; assert rst one cycle -> con_valid=0, STATUS=0x0004, CYCLES=0, and a read of 0x0005 returns 0x0077.
